// File: rtl/npu_pool_pkg.sv
// Shared types and defaults for the NPU pooling/argmax reduction path.
// Elements are packed {index, data}, with data in the low bits.
package npu_pool_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_INDEX_WIDTH = 16;
  localparam int DEF_LANES       = 4;
  localparam int DEF_LEN_WIDTH   = 16;
  localparam int EW              = DEF_INDEX_WIDTH + DEF_DATA_WIDTH;

  typedef struct packed {
    logic [DEF_INDEX_WIDTH-1:0] index;
    logic [DEF_DATA_WIDTH-1:0]  data;
  } elem_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_ACC   = 1'b1
  } state_t;

endpackage

// File: rtl/max_sel_cell.sv
// Two-input {index, data} max selector.
// Operand a wins on equal data, so callers place the earlier element on a.
module max_sel_cell #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 16
) (
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] a,
  input  logic [INDEX_WIDTH+DATA_WIDTH-1:0] b,
  input  logic                              sgn,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0] y
);

  logic w_a_ge_b;

  always_comb begin
    w_a_ge_b = 1'b0;
    if (sgn) begin
      w_a_ge_b = $signed(a[DATA_WIDTH-1:0]) >= $signed(b[DATA_WIDTH-1:0]);
    end else begin
      w_a_ge_b = a[DATA_WIDTH-1:0] >= b[DATA_WIDTH-1:0];
    end
  end

  assign y = w_a_ge_b ? a : b;

endmodule

// File: rtl/max_reduce_stream.sv
// Streaming max-with-index reducer: LANES elements per beat, cfg_len beats
// per window, one {index, data} result per window with valid/ready flow control.
module max_reduce_stream
  import npu_pool_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int LANES       = DEF_LANES,
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [LEN_WIDTH-1:0]                    cfg_len,
  input  logic                                    cfg_signed,
  input  logic                                    clr,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [LANES*(INDEX_WIDTH+DATA_WIDTH)-1:0] in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [INDEX_WIDTH+DATA_WIDTH-1:0]       out_data,
  output logic [LEN_WIDTH-1:0]                    out_count
);

  localparam int EWL   = INDEX_WIDTH + DATA_WIDTH;
  localparam int NODES = 2 * LANES - 1;

  state_t               r_state, w_state_next;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_next;
  logic [LEN_WIDTH-1:0] r_len, w_len_next;
  logic                 r_sgn, w_sgn_next;
  logic [EWL-1:0]       r_acc, w_acc_next;
  logic                 r_out_valid, w_out_valid_next;
  logic [EWL-1:0]       r_out_data, w_out_data_next;
  logic [LEN_WIDTH-1:0] r_out_count, w_out_count_next;

  logic                 w_fire;
  logic                 w_done;
  logic                 w_tree_sgn;
  logic [LEN_WIDTH-1:0] w_len_eff;
  logic [LEN_WIDTH-1:0] w_cnt_inc;
  logic [EWL-1:0]       w_acc_win;
  logic [EWL-1:0]       w_win;

  // Heap-ordered tree: node n lives at w_node[n-1], children are 2n and 2n+1.
  logic [EWL-1:0] w_node [NODES];

  assign in_ready   = !r_out_valid || out_ready;
  assign w_fire     = in_valid && in_ready;
  assign w_len_eff  = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  assign w_cnt_inc  = r_cnt + LEN_WIDTH'(1);
  // The first beat of a window is compared with the signedness it is about to latch.
  assign w_tree_sgn = (r_state == ST_EMPTY) ? cfg_signed : r_sgn;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_leaf
      assign w_node[LANES-1+gi] = in_data[gi*EWL +: EWL];
    end
    for (gi = 1; gi < LANES; gi++) begin : g_tree
      max_sel_cell #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
      ) u_cell (
        .a   (w_node[2*gi-1]),
        .b   (w_node[2*gi]),
        .sgn (w_tree_sgn),
        .y   (w_node[gi-1])
      );
    end
  endgenerate

  max_sel_cell #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_acc_cell (
    .a   (r_acc),
    .b   (w_node[0]),
    .sgn (r_sgn),
    .y   (w_acc_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_cnt       <= '0;
      r_len       <= '0;
      r_sgn       <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_len       <= w_len_next;
      r_sgn       <= w_sgn_next;
      r_acc       <= w_acc_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_count <= w_out_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_sgn_next   = r_sgn;
    w_acc_next   = r_acc;
    w_done       = 1'b0;
    w_win        = r_acc;

    if (clr) begin
      w_state_next = ST_EMPTY;
      w_cnt_next   = '0;
    end else if (w_fire) begin
      case (r_state)
        ST_EMPTY: begin
          w_len_next = w_len_eff;
          w_sgn_next = cfg_signed;
          w_acc_next = w_node[0];
          w_cnt_next = LEN_WIDTH'(1);
          if (w_len_eff == LEN_WIDTH'(1)) begin
            w_done = 1'b1;
            w_win  = w_node[0];
          end else begin
            w_state_next = ST_ACC;
          end
        end
        ST_ACC: begin
          w_acc_next = w_acc_win;
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_done       = 1'b1;
            w_win        = w_acc_win;
            w_state_next = ST_EMPTY;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // A completing beat is only accepted when the output slot is free or draining.
  always_comb begin
    w_out_valid_next = r_out_valid && !out_ready;
    w_out_data_next  = r_out_data;
    w_out_count_next = r_out_count;
    if (w_done) begin
      w_out_valid_next = 1'b1;
      w_out_data_next  = w_win;
      w_out_count_next = w_len_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_max_reduce_stream.sv
// Randomized and directed bench for max_reduce_stream against a window-level
// reference model that scans each completed window for its earliest maximum.
module tb_max_reduce_stream;
  import npu_pool_pkg::*;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int NL = 4;
  localparam int LW = 16;

  typedef struct {
    logic [EW-1:0] d;
    logic [LW-1:0] c;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [LW-1:0]   cfg_len = '0;
  logic            cfg_signed = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NL*EW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [EW-1:0]   out_data;
  logic [LW-1:0]   out_count;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          exp_q[$];
  logic [EW-1:0] cur_q[$];
  int            cur_beats = 0;
  int            cur_len   = 1;
  bit            cur_sgn   = 1'b0;
  bit            last_fire = 1'b0;
  bit            last_hs   = 1'b0;
  logic [EW-1:0] last_out  = '0;
  logic [LW-1:0] last_cnt  = '0;
  int            n_out     = 0;

  max_reduce_stream #(
    .DATA_WIDTH  (DW),
    .INDEX_WIDTH (IW),
    .LANES       (NL),
    .LEN_WIDTH   (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_len    (cfg_len),
    .cfg_signed (cfg_signed),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic bit data_gt(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit sgn);
    if (sgn) return $signed(x) > $signed(y);
    return x > y;
  endfunction

  // Earliest element (beat-major, lane-minor) holding the window maximum.
  function automatic logic [EW-1:0] ref_max(input logic [EW-1:0] elems[$], input bit sgn);
    elem_t best;
    elem_t e;
    best = elems[0];
    for (int i = 1; i < elems.size(); i++) begin
      e = elems[i];
      if (data_gt(e.data, best.data, sgn)) best = e;
    end
    return best;
  endfunction

  // One clock: sample #1 after the falling edge, update the model, advance.
  task automatic cycle();
    bit   pend;
    bit   fire;
    exp_t ex;
    #1;
    pend = (exp_q.size() != 0);
    check("out_valid", {63'd0, out_valid}, {63'd0, pend});
    check("in_ready", {63'd0, in_ready}, {63'd0, (!pend || out_ready)});
    if (pend) begin
      check("out_data", {40'd0, out_data}, {40'd0, exp_q[0].d});
      check("out_count", {48'd0, out_count}, {48'd0, exp_q[0].c});
    end
    fire = in_valid && (!pend || out_ready);
    last_hs = pend && out_ready;
    if (last_hs) begin
      last_out = out_data;
      last_cnt = out_count;
      n_out++;
      $display("[TB] out idx=0x%0h data=0x%0h count=%0d", out_data[EW-1:DW], out_data[DW-1:0], out_count);
      void'(exp_q.pop_front());
    end
    last_fire = fire && !clr;
    if (clr) begin
      cur_q.delete();
      cur_beats = 0;
    end else if (fire) begin
      if (cur_beats == 0) begin
        cur_len = (cfg_len == 0) ? 1 : int'(cfg_len);
        cur_sgn = cfg_signed;
      end
      for (int k = 0; k < NL; k++) cur_q.push_back(in_data[k*EW +: EW]);
      cur_beats++;
      if (cur_beats == cur_len) begin
        ex.d = ref_max(cur_q, cur_sgn);
        ex.c = LW'(cur_len);
        exp_q.push_back(ex);
        cur_q.delete();
        cur_beats = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one beat (lane k data = dv[k*8 +: 8], index = ib + k) until accepted.
  task automatic send_beat(input logic [31:0] dv, input logic [15:0] ib);
    for (int k = 0; k < NL; k++) in_data[k*EW +: EW] = {ib + 16'(k), dv[k*8 +: 8]};
    in_valid = 1'b1;
    last_fire = 1'b0;
    for (int t = 0; t < 20 && !last_fire; t++) cycle();
    check("beat_accept", {63'd0, last_fire}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int outs_before;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_data", {40'd0, out_data}, 64'd0);
    check("rst_out_count", {48'd0, out_count}, 64'd0);
    out_ready = 1'b1;
    idle(1);

    // Single window, unsigned
    cfg_len = 16'd2; cfg_signed = 1'b0;
    send_beat(32'h02_01_09_03, 16'h0000);
    send_beat(32'h00_07_04_05, 16'h0010);
    idle(2);
    check("t1_data", {40'd0, last_out}, 64'h000109);
    check("t1_count", {48'd0, last_cnt}, 64'd2);

    // Signed vs unsigned
    cfg_len = 16'd1; cfg_signed = 1'b1;
    send_beat(32'h01_00_7F_80, 16'h0020);
    idle(2);
    check("t2_signed", {40'd0, last_out}, 64'h00217F);
    cfg_signed = 1'b0;
    send_beat(32'h01_00_7F_80, 16'h0030);
    idle(2);
    check("t2_unsigned", {40'd0, last_out}, 64'h003080);

    // Tie-break
    cfg_len = 16'd3;
    send_beat(32'h05_05_05_05, 16'h0040);
    send_beat(32'h05_05_05_05, 16'h0044);
    send_beat(32'h05_05_05_05, 16'h0048);
    idle(2);
    check("t3_tie", {40'd0, last_out}, 64'h004005);
    check("t3_count", {48'd0, last_cnt}, 64'd3);

    // Backpressure with len=1 and in_valid held high
    cfg_len = 16'd1; out_ready = 1'b0; in_valid = 1'b1;
    outs_before = n_out;
    for (int i = 0; i < 4; i++) begin
      if (i == 0 || last_fire) in_data = {$urandom(), $urandom(), $urandom()};
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (last_fire) in_data = {$urandom(), $urandom(), $urandom()};
      cycle();
      check("bp_stream", {63'd0, last_hs}, 64'd1);
    end
    in_valid = 1'b0;
    idle(2);
    check("bp_outs", 64'(n_out - outs_before), 64'd6);

    // clr after 2 of 4 beats, with a beat in the clr cycle, then cfg_len=0
    cfg_len = 16'd4;
    send_beat(32'h11_22_33_44, 16'h0050);
    send_beat(32'h55_66_77_7E, 16'h0054);
    outs_before = n_out;
    clr = 1'b1; in_valid = 1'b1;
    idle(1);
    clr = 1'b0; in_valid = 1'b0;
    cfg_len = 16'd0;
    send_beat(32'h10_20_30_40, 16'h0060);
    send_beat(32'h90_20_30_40, 16'h0064);
    send_beat(32'h01_02_03_04, 16'h0068);
    idle(2);
    check("clr_outs", 64'(n_out - outs_before), 64'd3);
    check("len0_count", {48'd0, last_cnt}, 64'd1);

    // Asynchronous reset mid-window
    cfg_len = 16'd4;
    send_beat(32'hF0_F1_F2_F3, 16'h0070);
    send_beat(32'hE0_E1_E2_E3, 16'h0074);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    cur_q.delete(); cur_beats = 0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cfg_len = 16'd2;
    send_beat(32'h01_02_03_04, 16'h0080);
    send_beat(32'h08_07_06_05, 16'h0084);
    idle(2);
    check("rst_next_data", {40'd0, last_out}, 64'h008708);
    check("rst_next_count", {48'd0, last_cnt}, 64'd2);

    // Randomized traffic with mid-window config changes, clr and backpressure
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = {$urandom(), $urandom(), $urandom()};
      end
      cfg_len    = LW'($urandom_range(0, 4));
      cfg_signed = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 9) < 7);
      clr        = ($urandom_range(0, 19) == 0);
      cycle();
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max_reduce_stream.md
# max_reduce_stream

Streaming max-reduction unit for the NPU pooling and argmax paths. Each beat carries LANES packed {index, data} elements. The block reduces them over a configurable window of beats and emits one {index, data} result per window. It generalises the pairwise max-with-index selector into a multi-lane, multi-beat, backpressured reducer with signed/unsigned selection. It sits between the PE array output and the pooling/argmax writeback.

## Interface
- DATA_WIDTH, 8, element data width in bits.
- INDEX_WIDTH, 16, element index width carried alongside data.
- LANES, 4, elements per beat; power of two, 1..16.
- LEN_WIDTH, 16, width of the window-length field.
- Element width EW = INDEX_WIDTH + DATA_WIDTH. Each element is packed {index[EW-1:DATA_WIDTH], data[DATA_WIDTH-1:0]}.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- cfg_len  in  LEN_WIDTH  beats per window; 0 is treated as 1; sampled on the first beat of each window.
- cfg_signed  in  1  1 = compare data as two's complement, 0 = unsigned; sampled with cfg_len.
- clr  in  1  synchronous drop of the partial window; does not touch a pending output.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  LANES*EW  lane k occupies bits [k*EW +: EW].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  EW  winning {index, data}.
- out_count  out  LEN_WIDTH  number of beats reduced into out_data (diagnostic).

## Operation
- **Compare rule:** select a over b when a.data >= b.data, using the signedness latched for the window. The full EW word travels with the winner.
- **Ties:** equal data resolves to the earlier element. Lower lane wins within a beat. The accumulator (earlier beats) wins over the incoming beat.
- **Lane reduction:** combinational binary tree of compare cells over the LANES elements. Pairs are (0,1), (2,3), …, with the lower-numbered operand as "a" at every level.
- **States:**
  - EMPTY: no partial window.
  - ACC: partial window held in acc_reg, with beat counter cnt.
- **Transitions on an accepted beat:**
  - In EMPTY: latch len_q = max(cfg_len, 1) and sgn_q = cfg_signed. Set acc_reg = tree result and cnt = 1.
    - If len_q == 1, complete the window immediately and stay in EMPTY.
    - Otherwise go to ACC.
  - In ACC: acc_reg = cmp(acc_reg, tree result) and cnt increments.
    - When cnt + 1 == len_q, complete the window and go to EMPTY.
- **Window completion:** out_data = final winner, out_count = len_q, out_valid = 1.
- **Flow control:** in_ready = !out_valid || out_ready. A completing beat is only accepted when the output register is free or is being drained in the same cycle.
- **clr:** forces EMPTY and cnt = 0 next cycle. clr has priority over a beat accepted in the same cycle; that beat is discarded. out_valid and out_data are unaffected.
- **Config changes:** changes to cfg_len or cfg_signed mid-window have no effect until the next window.

## Timing
- **Reset values:**
  - out_valid = 0, out_data = 0, out_count = 0.
  - State EMPTY, cnt = 0, acc_reg = 0.
  - in_ready = 1 after reset, since it is combinational from out_valid.
- **Latency:** out_valid rises the cycle after the last beat of a window is accepted (1 cycle).
- **Throughput:** 1 beat per cycle. Back-to-back windows, including len = 1 windows, run at full rate while out_ready is held high.
- **Output handshake:** out_data and out_count stay stable while out_valid && !out_ready. out_valid drops the cycle after a handshake unless a new window completes in that same cycle, in which case out_valid stays high with the new data.
- **Stall:** a partial window waits indefinitely while in_valid is low.
- **Counter width:** cnt is LEN_WIDTH bits. len = 2^LEN_WIDTH − 1 completes without wrap.
- **Reset mid-window:** the partial result is lost. No output is produced for that window.

## Structure
- Shared package npu_pool_pkg holds:
  - the element-width constant EW,
  - the packed element typedef (index/data fields),
  - the default parameter values.
- One sub-module, max_sel_cell: a combinational two-input {index, data} selector with a signed/unsigned control input and the >= tie rule. It is instantiated LANES−1 times in the tree plus once for the accumulator.
- The FSM, counter and output register live in the top module.

## Test plan
- **Single window, unsigned:** LANES=4, cfg_len=2, cfg_signed=0. Beats with data {3,9,1,2} then {5,4,7,0}. Required: out_data.data = 9, index of lane 1 beat 0, out_count = 2, one cycle after the 2nd beat.
- **Signed vs unsigned:** cfg_len=1, data {0x80,0x7F,0x00,0x01}. Required: signed → 0x7F (lane 1); unsigned → 0x80 (lane 0).
- **Tie-break:** cfg_len=3, every element data = 5, distinct indices. Required: index of beat 0, lane 0.
- **Backpressure:** cfg_len=1, in_valid held high, out_ready low for 4 cycles. Required:
  - in_ready = 0 while out_valid is held;
  - out_data is stable;
  - no beat is lost;
  - the results stream at 1 per cycle after out_ready rises.
- **clr and cfg_len=0:** clr mid-window after 2 of 4 beats, then cfg_len=0 beats. Required: no output for the aborted window; each subsequent beat yields one result with out_count = 1.
- **Reset mid-window:** assert rst_n low asynchronously during ACC. Required: out_valid = 0 immediately, and the next window starts clean with cnt = 1 on its first beat.
